// File: rtl/switch_bounce_gen_if.sv
// Switch emulator signal bundle: commanded level in, bouncy level and status out.
interface switch_bounce_gen_if;
  logic BtnCmd;
  logic SwOut;
  logic Busy;
  logic Done;

  modport master (output BtnCmd, input SwOut, input Busy, input Done);
  modport slave  (input BtnCmd, output SwOut, output Busy, output Done);
endinterface

// File: rtl/switch_bounce_gen.sv
// Mechanical-switch emulator: each commanded edge becomes an odd burst of LFSR-timed chatter.
// Define SWITCH_BOUNCE_GEN_RELEASE_EN to make releases bounce like presses.
module switch_bounce_gen #(
  parameter int unsigned BOUNCE_W = 2,
  parameter int unsigned GAP_W    = 2,
  parameter int unsigned HOLD     = 8,
  parameter logic [7:0]  SEED     = 8'hA5
) (
  input  logic               Clk1ms,
  input  logic               Reset,
  switch_bounce_gen_if.slave sw
);

  localparam int unsigned REM_W  = BOUNCE_W + 1;
  localparam int unsigned GAP_CW = GAP_W + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD + 1);
  localparam logic [7:0]        SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD);

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

  state_t              state;
  logic [7:0]          lfsr;
  logic [7:0]          lfsrNext;
  logic [REM_W-1:0]    rem;
  logic [GAP_CW-1:0]   gapCnt;
  logic [HOLD_W-1:0]   holdCnt;
  logic                swOut;
  logic                busy;
  logic                done;
  logic [BOUNCE_W-1:0] kSample;
  logic [REM_W-1:0]    remLoad;
  logic [GAP_CW-1:0]   gapLoad;

  assign sw.SwOut = swOut;
  assign sw.Busy  = busy;
  assign sw.Done  = done;

  // x^8+x^6+x^5+x^4+1
  assign lfsrNext = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  always_comb begin
    kSample = lfsr[BOUNCE_W-1:0];
`ifdef SWITCH_BOUNCE_GEN_RELEASE_EN
`else
    // Release (target level 0): single clean toggle.
    if (!sw.BtnCmd) kSample = '0;
`endif
    remLoad = {kSample, 1'b0};
    gapLoad = GAP_CW'(lfsr[BOUNCE_W+GAP_W-1:BOUNCE_W]) + GAP_CW'(1);
  end

  always_ff @(posedge Clk1ms) begin
    if (Reset) begin
      state   <= IDLE;
      lfsr    <= SEED_EFF;
      rem     <= '0;
      gapCnt  <= '0;
      holdCnt <= '0;
      swOut   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      lfsr <= lfsrNext;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sw.BtnCmd != swOut) begin
            swOut  <= ~swOut;
            rem    <= remLoad;
            gapCnt <= gapLoad;
            busy   <= 1'b1;
            state  <= BOUNCE;
          end
        end
        BOUNCE: begin
          if (rem == '0) begin
            holdCnt <= HOLD_LOAD;
            state   <= SETTLE;
          end else if (gapCnt == GAP_CW'(1)) begin
            swOut  <= ~swOut;
            rem    <= rem - REM_W'(1);
            gapCnt <= gapLoad;
          end else begin
            gapCnt <= gapCnt - GAP_CW'(1);
          end
        end
        SETTLE: begin
          if (holdCnt == HOLD_W'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            holdCnt <= holdCnt - HOLD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/switch_bounce_gen.md
# switch_bounce_gen

Synthesizable mechanical-switch emulator driven by a clean commanded level. Each commanded transition is reproduced on `SwOut` as an odd-length burst of pseudo-random chatter, then held stable. It is the stimulus end of the debouncer path: its `SwOut` feeds a debouncer's switch input on the same `Clk1ms` tick, for on-board demos and bench regression.

## Interface
- `BOUNCE_W`, default 2: width of the bounce-count field. The burst has 2K+1 toggles, K = LFSR[BOUNCE_W-1:0], so 1 to 2^(BOUNCE_W+1)-1 toggles.
- `GAP_W`, default 2: width of the gap field. Gap G = LFSR[BOUNCE_W+GAP_W-1:BOUNCE_W] + 1, i.e. 1..2^GAP_W ticks. BOUNCE_W+GAP_W ≤ 8.
- `HOLD`, default 8: settle ticks after the final toggle, ≥1. Command changes are not sampled during these ticks.
- `SEED`, default 8'hA5: LFSR reset value. A value of 0 is replaced by 8'h01.
- `Clk1ms  in  1`: 1 ms tick clock, rising edge.
- `Reset  in  1`: synchronous, active-high reset.
- `BtnCmd  in  1`: clean commanded switch level.
- `SwOut  out  1`: emulated bouncy switch output, registered.
- `Busy  out  1`: high while in BOUNCE or SETTLE.
- `Done  out  1`: one-cycle pulse on return to IDLE.

## Operation
- **LFSR**
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Shifts every cycle; it is not gated by state.
  - K and G are sampled from the current LFSR value at the moment they are loaded.
- **IDLE**
  - If `BtnCmd != SwOut`, then on this edge: toggle `SwOut`, set Rem ← 2K, set GapCnt ← G, go to BOUNCE.
  - Otherwise hold.
- **BOUNCE**
  - If Rem == 0: go to SETTLE and set HoldCnt ← HOLD.
  - Else if GapCnt == 1: toggle `SwOut`, Rem ← Rem-1, GapCnt ← new G.
  - Else: GapCnt ← GapCnt-1.
- **SETTLE**
  - If HoldCnt == 1: go to IDLE and pulse `Done`.
  - Else: HoldCnt ← HoldCnt-1.
- **Widths**: Rem is BOUNCE_W+1 bits. GapCnt is GAP_W+1 bits. HoldCnt is $clog2(HOLD+1) bits.
- **Final level**: the toggle count is always odd, so the final `SwOut` equals the `BtnCmd` level sampled at entry.
- **Command changes during BOUNCE/SETTLE** are ignored and not queued. IDLE re-compares on its first cycle and starts a new burst immediately if the levels differ. A glitch that fully reverts before IDLE produces nothing.

## Timing
- **Reset values**: `SwOut`=0, `Busy`=0, `Done`=0, state=IDLE, LFSR=SEED (or 8'h01), all counters 0.
- **Reset mid-burst** aborts the burst. `SwOut` is 0 on the cycle after the reset edge.
- **Latency**: first `SwOut` toggle is 1 cycle after `BtnCmd` differs from `SwOut` at an edge.
- **Toggle spacing** within a burst is G cycles, with G resampled per toggle.
- **After the last toggle**: 1 cycle in BOUNCE (the Rem==0 check), then HOLD cycles in SETTLE.
- **Busy span**:
  - Busy rises with the first toggle.
  - Busy falls on the same edge that `Done` pulses.
  - Busy span = sum of all gaps + 1 + HOLD cycles.
- **Back-to-back bursts**: the earliest possible next toggle is 1 cycle after `Done`, because IDLE registers the comparison.

## Configuration
- Macro: `SWITCH_BOUNCE_GEN_RELEASE_EN`.
- Applies to releases only, i.e. transitions where the target is 0.
- **Defined**: releases bounce exactly like presses.
- **Undefined**: on a release K is forced to 0. The release is a single clean toggle followed by 1+HOLD busy cycles. Presses still bounce.

## Test plan
- **Reset**: assert `Reset` for 2 cycles, `BtnCmd`=0 → `SwOut`=0, `Busy`=0, `Done`=0, and no toggles for 20 cycles.
- **Press burst**: `BtnCmd` 0→1 with defaults.
  - `SwOut` toggle count is odd, between 1 and 7.
  - Final `SwOut`=1.
  - Each gap is 1..4 cycles.
  - `Done` pulses exactly once, HOLD+1 cycles after the last toggle.
- **Release without the macro**: `BtnCmd` 1→0 with `SWITCH_BOUNCE_GEN_RELEASE_EN` undefined and HOLD=8 → a single fall 1 cycle later, `Busy` high for exactly 9 cycles, then `Done`.
- **Mid-burst command change**: `BtnCmd` 0→1, then 1→0 two cycles later.
  - The burst completes to `SwOut`=1.
  - One cycle after `Done`, a new burst starts.
  - It ends at `SwOut`=0.
- **Mid-burst reset**: assert `Reset` during BOUNCE → next cycle `SwOut`=0, `Busy`=0, and no `Done` pulse.
- **Determinism and SEED=0**:
  - Two runs with SEED=8'hA5 and the same stimulus produce identical `SwOut` traces.
  - SEED=0 still bounces, with behaviour identical to SEED=8'h01.
